// File: rtl/fifo_param_prog.sv
// Parametrised lane FIFO with programmable almost-full/almost-empty thresholds,
// occupancy count, sticky error flag and a compile-time registered/FWFT read mode.
module fifo_param_prog #(
  parameter int DATA_SIZE = 10,
  parameter int MAIN_SIZE = 8,
  parameter int PTR_SIZE  = 3,
  parameter int FWFT      = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write,
  input  logic                 read,
  input  logic [DATA_SIZE-1:0] data_in_push,
  input  logic [PTR_SIZE:0]    umbral_alto,
  input  logic [PTR_SIZE:0]    umbral_bajo,
  input  logic                 err_clear,
  output logic [DATA_SIZE-1:0] data_out_pop,
  output logic                 valid_out,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 Fifo_full,
  output logic                 fifo_empty,
  output logic                 fifo_error,
  output logic [PTR_SIZE:0]    occupancy
);

  localparam logic [PTR_SIZE:0]   FULL_COUNT = (PTR_SIZE+1)'(MAIN_SIZE);
  localparam logic [PTR_SIZE:0]   OCC_ONE    = (PTR_SIZE+1)'(1);
  localparam logic [PTR_SIZE-1:0] PTR_ONE    = PTR_SIZE'(1);

  logic [DATA_SIZE-1:0] mem [MAIN_SIZE];
  logic [PTR_SIZE-1:0]  wr_ptr;
  logic [PTR_SIZE-1:0]  rd_ptr;
  logic                 rd_acc;
  logic                 wr_acc;
  logic                 overflow;
  logic                 underflow;

  // A full FIFO still takes a write when the same cycle frees a slot.
  assign rd_acc    = read & ~fifo_empty;
  assign wr_acc    = write & (~Fifo_full | rd_acc);
  assign overflow  = write & Fifo_full & ~rd_acc;
  assign underflow = read & fifo_empty;

  assign fifo_empty   = (occupancy == '0);
  assign Fifo_full    = (occupancy == FULL_COUNT);
  assign almost_full  = (occupancy >= umbral_alto);
  assign almost_empty = (occupancy <= umbral_bajo);

  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      mem[wr_ptr] <= data_in_push;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (wr_acc && !rd_acc) begin
        occupancy <= occupancy + OCC_ONE;
      end else if (rd_acc && !wr_acc) begin
        occupancy <= occupancy - OCC_ONE;
      end
    end
  end

  // A new error in the same cycle as err_clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_error <= 1'b0;
    end else if (overflow || underflow) begin
      fifo_error <= 1'b1;
    end else if (err_clear) begin
      fifo_error <= 1'b0;
    end
  end

  generate
    if (FWFT == 0) begin : g_registered
      logic [DATA_SIZE-1:0] rd_data;
      logic                 rd_valid;

      always_ff @(posedge clk) begin
        if (reset) begin
          rd_data  <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= rd_acc;
          if (rd_acc) begin
            rd_data <= mem[rd_ptr];
          end
        end
      end

      assign data_out_pop = rd_data;
      assign valid_out    = rd_valid;
    end else begin : g_fwft
      // Masked while empty so the output shows zero rather than stale memory.
      assign data_out_pop = fifo_empty ? '0 : mem[rd_ptr];
      assign valid_out    = ~fifo_empty;
    end
  endgenerate

endmodule

// File: doc/fifo_param_prog.md
Name: fifo_param_prog

Overview:
Parametrised successor to the 8x10 fifo_param, used as the per-lane buffer in the PCIe switching datapath. It adds programmable almost-full/almost-empty thresholds, an occupancy count and a sticky, clearable error flag. It also offers a compile-time choice between a registered-read mode and a first-word-fall-through (FWFT) mode. It sits between the lane demux/mux stages and is flow-controlled by the downstream arbiter through read, almost_full and almost_empty.

Parameters:
DATA_SIZE, 10, word width in bits.
MAIN_SIZE, 8, depth in words; power of two, minimum 4.
PTR_SIZE, 3, log2(MAIN_SIZE); pointer width.
FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through.

Ports:
clk  in  1  single clock, all logic on rising edge.
reset  in  1  synchronous, active-high reset.
write  in  1  push request.
read  in  1  pop request (FWFT=1: acknowledge of the presented word).
data_in_push  in  DATA_SIZE  write data.
umbral_alto  in  PTR_SIZE+1  almost-full threshold.
umbral_bajo  in  PTR_SIZE+1  almost-empty threshold.
err_clear  in  1  clears fifo_error.
data_out_pop  out  DATA_SIZE  read data.
valid_out  out  1  data_out_pop holds a valid popped/presented word.
almost_full  out  1  occupancy >= umbral_alto.
almost_empty  out  1  occupancy <= umbral_bajo.
Fifo_full  out  1  occupancy == MAIN_SIZE.
fifo_empty  out  1  occupancy == 0.
fifo_error  out  1  sticky overflow/underflow indicator.
occupancy  out  PTR_SIZE+1  current word count, 0..MAIN_SIZE.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high, on port reset; it is sampled only at the rising edge of clk and overrides all other inputs.
- Reset values:
  - wr_ptr = rd_ptr = 0, occupancy = 0.
  - data_out_pop = 0, valid_out = 0, fifo_error = 0.
  - fifo_empty = 1, Fifo_full = 0, almost_full = 0 unless umbral_alto = 0.
  - almost_empty = 1.
  - Memory contents are not reset.
- Accept rules, evaluated on pre-edge state:
  - wr_acc = write & (!Fifo_full | rd_acc).
  - rd_acc = read & !fifo_empty.
- Accepted write: mem[wr_ptr] <= data_in_push; wr_ptr advances and wraps modulo MAIN_SIZE.
- Accepted read: rd_ptr advances and wraps modulo MAIN_SIZE.
- Occupancy update:
  - wr_acc & !rd_acc: +1.
  - rd_acc & !wr_acc: -1.
  - both or neither: unchanged.
- Simultaneous read+write when full: both are accepted, no error, and occupancy stays MAIN_SIZE.
- Simultaneous read+write when empty: the write is accepted and the read is rejected as an underflow.
- Flags are combinational decodes of the registered occupancy and the threshold inputs. They change in the cycle after the causing edge. A threshold change takes effect immediately.
- Threshold extremes:
  - umbral_alto = 0 forces almost_full high.
  - umbral_alto > MAIN_SIZE keeps almost_full low.
  - umbral_bajo >= MAIN_SIZE forces almost_empty high.
- FWFT=0:
  - On rd_acc, data_out_pop <= mem[rd_ptr] and valid_out <= 1 for exactly one cycle.
  - Otherwise valid_out <= 0 and data_out_pop holds its last value.
  - Read latency is 1 cycle.
- FWFT=1:
  - data_out_pop = mem[rd_ptr] and valid_out = !fifo_empty, both combinational from registered state.
  - A write into an empty FIFO is visible the cycle after the write edge.
  - read pops the presented word.
- Error flag:
  - Overflow is write & Fifo_full & !rd_acc; the data is dropped.
  - Underflow is read & fifo_empty.
  - Either event sets fifo_error at the next edge; it is sticky.
  - err_clear clears it at the next edge.
  - If err_clear and a new error occur in the same cycle, the error wins and fifo_error stays 1.
  - Error events never change pointers or occupancy.
- Reset mid-operation: all stored words are discarded and the next cycle shows the reset values.

Test Plan:
1. MAIN_SIZE=8, DATA_SIZE=10, FWFT=0, umbral_alto=6, umbral_bajo=2. Write 0x001..0x008 on consecutive cycles -> almost_empty falls after the 3rd write edge, almost_full rises after the 6th, Fifo_full=1 and occupancy=8 after the 8th, fifo_error=0 throughout.
2. From full, write 0x3FF alone -> fifo_error=1 next cycle, occupancy stays 8. Then read 8 times -> data_out_pop = 0x001..0x008, each with valid_out=1 one cycle after its read; fifo_empty=1 at the end; 0x3FF never appears.
3. Empty FIFO, read=1 for one cycle -> fifo_error=1, occupancy=0, valid_out=0. Then pulse err_clear -> fifo_error=0 next cycle. Then assert err_clear together with read on empty -> fifo_error remains 1.
4. Full FIFO holding 0x001..0x008, write 0x009 with read in the same cycle -> no error, occupancy=8, data_out_pop=0x001 next cycle. Later drain order ends ...0x008, 0x009.
5. Interleave 20 writes (0x100+i) with reads, keeping occupancy at 3..5 so both pointers wrap at least twice -> output sequence is exactly 0x100..0x113, no flag glitches, no error.
6. Load 5 words, assert reset for one cycle mid-stream -> next cycle occupancy=0, fifo_empty=1, data_out_pop=0, valid_out=0. With FWFT=1, write 0x155 -> next cycle data_out_pop=0x155 and valid_out=1 with no read; after read, valid_out=0.
